// File: rtl/mem_byte_sequencer_pkg.sv
// Shared types for the big-endian byte load/store sequencer:
// request size encodings, FSM state enum and the size decoder.
package mem_seq_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_W = 2'd1;
  localparam logic [1:0] SIZE_L = 2'd2;
  localparam logic [1:0] SIZE_Q = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  function automatic int unsigned size_to_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// CPU-side request/response bus of the byte sequencer.
// The CPU core is the master, the sequencer is the slave.
interface mem_byte_sequencer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_BYTES = 4
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [8*DATA_BYTES-1:0] req_wdata;
  logic                    rsp_valid;
  logic                    rsp_error;
  logic [8*DATA_BYTES-1:0] rsp_rdata;
  logic                    busy;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_error, rsp_rdata, busy
  );

endinterface

// File: rtl/mem_byte_sequencer_rd_track.sv
// Read-return tracker: delays the "load byte issued" marker so capture_en
// lines up with the cycle in which the RAM presents that byte.
module rd_track #(
  parameter int RD_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_next,
  output logic capture_en
);

  // pipe[0] is high while a load byte address is on mem_raddr; the tap at
  // RD_LATENCY-1 marks the cycle whose closing edge samples that byte.
  logic [RD_LATENCY-1:0] pipe;

  generate
    if (RD_LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) pipe <= '0;
        else       pipe <= issue_next;
      end
    end else begin : g_deep
      always_ff @(posedge clk) begin
        if (reset) pipe <= '0;
        else       pipe <= {pipe[RD_LATENCY-2:0], issue_next};
      end
    end
  endgenerate

  assign capture_en = pipe[RD_LATENCY-1];

endmodule

// File: rtl/mem_byte_sequencer.sv
// Big-endian load/store sequencer: splits one 1/2/4(/8)-byte request into
// single-byte accesses on a byte-wide synchronous RAM.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ISSUE | one byte address (and write for stores) per cycle, N cycles
// DRAIN | loads only: RD_LATENCY cycles for outstanding read bytes
// RESP  | one-cycle rsp_valid, rsp_error if the size was illegal
module mem_byte_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_BYTES = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_byte_sequencer_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_data_out,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write
);

  localparam int          CW        = $clog2(DATA_BYTES) + 1;
  localparam int          DW        = 8 * DATA_BYTES;
  localparam int unsigned MAX_BYTES = DATA_BYTES;

  seq_state_t state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic                  err_q;
  logic [DW-1:0]         wdata_q;
  logic [DW-1:0]         rdata_q;

  logic          accept;
  logic          req_legal;
  logic          issue_next;
  logic          capture_en;
  logic [CW-1:0] last_idx;
  logic [CW-1:0] offset;

  assign accept    = (state_q == IDLE) & bus.req_valid;
  assign req_legal = size_to_bytes(bus.req_size) <= MAX_BYTES;

  // cnt_q counts down from N-1, so it is also the big-endian byte lane
  // of the current byte; the address offset is its complement.
  assign last_idx = CW'(size_to_bytes(size_q) - 32'd1);
  assign offset   = last_idx - cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_legal) begin
            state_d = ISSUE;
            cnt_d   = CW'(size_to_bytes(bus.req_size) - 32'd1);
          end else begin
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            state_d = RESP;
          end else begin
            state_d = DRAIN;
            cnt_d   = CW'(RD_LATENCY - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue_next = (state_d == ISSUE) & (accept ? ~bus.req_write : ~write_q);

  rd_track #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_track (
    .clk        (clk),
    .reset      (reset),
    .issue_next (issue_next),
    .capture_en (capture_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        write_q <= bus.req_write;
        err_q   <= ~req_legal;
        wdata_q <= bus.req_wdata;
        if (~bus.req_write | ~req_legal) rdata_q <= '0;
      end else if (capture_en) begin
        rdata_q <= {rdata_q[DW-9:0], mem_data_out};
      end
    end
  end

  assign mem_raddr   = addr_q + ADDR_WIDTH'(offset);
  assign mem_waddr   = addr_q + ADDR_WIDTH'(offset);
  assign mem_data_in = wdata_q[8*cnt_q +: 8];
  // Gated by reset so an abort suppresses the write in the reset cycle too.
  assign mem_write   = (state_q == ISSUE) & write_q & ~reset;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_error = (state_q == RESP) & err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: directed cases plus random traffic checked
// against a byte-array memory model and latency rules.
module tb_mem_byte_sequencer;

  localparam int AW    = 9;
  localparam int DB    = 4;
  localparam int RDL   = 2;
  localparam int DW    = 8 * DB;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_data_out;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_data_in;
  logic          mem_write;

  mem_byte_sequencer_if #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) bus ();

  mem_byte_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_BYTES (DB),
    .RD_LATENCY (RDL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .mem_raddr    (mem_raddr),
    .mem_data_out (mem_data_out),
    .mem_waddr    (mem_waddr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write)
  );

  always #5 clk = ~clk;

  // RAM device; updated on the falling edge so the DUT sees settled data.
  logic [7:0]    ram       [DEPTH];
  logic [7:0]    model_mem [DEPTH];
  logic [AW-1:0] hist      [4];
  logic          pl_copy = 1'b0;
  int            wr_total = 0;

  always @(negedge clk) begin
    if (pl_copy) for (int j = 0; j < DEPTH; j++) ram[j] <= model_mem[j];
    if (mem_write) begin
      ram[mem_waddr] <= mem_data_in;
      wr_total       <= wr_total + 1;
    end
    hist[0] <= mem_raddr;
    for (int k = 1; k < 4; k++) hist[k] <= hist[k-1];
  end

  assign mem_data_out = ram[hist[RDL-1]];

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_ram();
    pl_copy = 1'b1;
    @(negedge clk);
    #1 pl_copy = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_image(input string tag);
    int mism = 0;
    for (int j = 0; j < DEPTH; j++) if (ram[j] !== model_mem[j]) mism++;
    check(tag, mism, 0);
  endtask

  // Called at a falling edge; returns at the falling edge of the rsp_valid cycle.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic [AW-1:0] ad,
                        input logic [63:0] wd, input bit keep, input int exp_wait);
    int          n     = 1 << sz;
    bit          legal = (n <= DB);
    int          lat   = !legal ? 1 : (wr ? n + 1 : n + RDL + 1);
    logic [63:0] exp   = '0;
    logic [63:0] wmask = (DW == 64) ? '1 : ((64'd1 << DW) - 64'd1);
    logic [63:0] wdm   = wd & wmask;
    int          w     = 0;
    int          got   = 0;
    int          wr0;
    bit          busy_ok = 1'b1;
    logic [AW-1:0] a;

    if (legal && !wr)
      for (int i = 0; i < n; i++) begin
        a   = ad + AW'(i);
        exp = (exp << 8) | 64'(model_mem[a]);
      end

    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_addr  = ad;
    bus.req_wdata = wdm[DW-1:0];
    bus.req_valid = 1'b1;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (exp_wait >= 0) check("accept_wait", w, exp_wait);
    wr0 = wr_total;
    @(posedge clk);
    #1 if (!keep) bus.req_valid = 1'b0;

    for (int k = 1; k <= 40 && got == 0; k++) begin
      @(negedge clk);
      if (!bus.busy || bus.req_ready) busy_ok = 1'b0;
      if (bus.rsp_valid) got = k;
    end

    if (!legal || !wr) last_rdata = exp;
    check("rsp_latency", got, lat);
    check("rsp_error", bus.rsp_error, !legal);
    check("busy_during", busy_ok, 1);
    check("rsp_rdata", 64'(bus.rsp_rdata), last_rdata);
    check("write_count", wr_total - wr0, (legal && wr) ? n : 0);

    if (legal && wr)
      for (int i = 0; i < n; i++) begin
        a            = ad + AW'(i);
        model_mem[a] = 8'((wdm >> (8 * (n - 1 - i))) & 64'hFF);
      end
    check_image("ram_image");
  endtask

  initial begin
    bit          quiet;
    int          wr0;
    int          idle;
    int          nxt_wait;
    logic [63:0] wd;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int j = 0; j < DEPTH; j++) model_mem[j] = 8'($urandom);
    pl_copy = 1'b1;
    repeat (3) @(negedge clk);
    pl_copy = 1'b0;
    reset   = 1'b0;
    @(negedge clk);

    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 0);
    check("rst_mem_raddr", mem_raddr, 0);
    check("rst_mem_waddr", mem_waddr, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check_image("rst_ram_image");

    model_mem[9'h010] = 8'h12;
    model_mem[9'h011] = 8'h34;
    model_mem[9'h012] = 8'h56;
    model_mem[9'h013] = 8'h78;
    model_mem[9'h005] = 8'h9C;
    sync_ram();
    do_req(1'b0, 2'd2, 9'h010, 64'd0, 1'b0, 0);
    check("tp_load_word", 64'(bus.rsp_rdata), 64'h12345678);
    repeat (2) @(negedge clk);

    do_req(1'b1, 2'd1, 9'h1FF, 64'hABCD, 1'b0, 0);
    check("tp_wrap_hi", ram[9'h1FF], 8'hAB);
    check("tp_wrap_lo", ram[9'h000], 8'hCD);
    repeat (2) @(negedge clk);

    do_req(1'b0, 2'd0, 9'h005, 64'd0, 1'b0, 0);
    check("tp_byte_load", 64'(bus.rsp_rdata), 64'h9C);
    repeat (2) @(negedge clk);

    do_req(1'b0, 2'd3, 9'h020, 64'd0, 1'b0, 0);
    repeat (2) @(negedge clk);

    // Abort a 4-byte store with reset during its second write cycle.
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 9'h040;
    bus.req_wdata = DW'(64'hDEADBEEF);
    bus.req_valid = 1'b1;
    wr0 = wr_total;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy || !bus.req_ready || mem_write) quiet = 1'b0;
    end
    check("reset_abort_quiet", quiet, 1);
    check("reset_abort_writes", wr_total - wr0, 1);
    model_mem[9'h040] = 8'hDE;
    check_image("reset_ram_image");

    wd = {$urandom, $urandom};
    do_req(1'b1, 2'd2, 9'h0F0, wd, 1'b1, 0);
    do_req(1'b0, 2'd2, 9'h0F0, 64'd0, 1'b0, 1);
    check("b2b_readback", 64'(bus.rsp_rdata), wd & 64'hFFFF_FFFF);

    nxt_wait = 1;
    for (int t = 0; t < 40; t++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, 1'b0, nxt_wait);
      idle = $urandom_range(0, 2);
      repeat (idle) @(negedge clk);
      nxt_wait = (idle == 0) ? 1 : 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Parametrised big-endian load/store sequencer. It turns one multi-byte request (1, 2 or 4 bytes; wider when DATA_BYTES allows) into a run of single-byte accesses on a byte-wide synchronous RAM.
- It replaces the hard-wired per-byte load/store flags and EXEC-state chains in the CPU. It sits between the CPU core and the byte RAM.
- Read latency, address width and maximum word width are configurable.

Parameters:
- ADDR_WIDTH, 9, width of memory byte addresses.
- DATA_BYTES, 4, maximum bytes per request; 4 or 8.
- RD_LATENCY, 2, cycles from presenting mem_raddr to sampling mem_data_out; 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = 1 byte, 1 = 2, 2 = 4, 3 = 8 bytes
- req_addr  in  ADDR_WIDTH  address of the most significant byte
- req_wdata  in  8*DATA_BYTES  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_error  out  1  qualifies rsp_valid: illegal size
- rsp_rdata  out  8*DATA_BYTES  load result, zero-extended, right-aligned
- busy  out  1  high from accept through the rsp_valid cycle
- mem_raddr  out  ADDR_WIDTH  RAM read address
- mem_data_out  in  8  RAM read data
- mem_waddr  out  ADDR_WIDTH  RAM write address
- mem_data_in  out  8  RAM write data
- mem_write  out  1  RAM write strobe

Behaviour:
- Reset is synchronous, active-high; clock is clk. After the reset edge:
  - state IDLE
  - req_ready 1
  - rsp_valid, rsp_error, busy, mem_write all 0
  - rsp_rdata, mem_raddr, mem_waddr, mem_data_in all 0
- Reset mid-operation aborts immediately. No further mem_write pulses occur and no rsp_valid is produced.
- req_ready = (state == IDLE). One request is outstanding at a time.
- Let N = 1 << req_size. The request is illegal if N > DATA_BYTES.
- Accept happens at edge T. Address, size, write flag and wdata are captured there, and rsp_rdata is cleared for loads.
- Illegal request: no RAM activity. rsp_valid = rsp_error = 1 in cycle T+1, rsp_rdata = 0.
- Byte order is big-endian. Byte i (i = 0..N-1) lives at addr+i and maps to bits [8*(N-1-i) +: 8]. Address arithmetic wraps modulo 2^ADDR_WIDTH. Unaligned addresses are legal.
- Store: in cycles T+1..T+N, mem_write = 1, mem_waddr = addr+i, mem_data_in = byte i. rsp_valid is high in cycle T+N+1. mem_write is never high outside these cycles.
- Load: mem_raddr = addr+i during cycle T+1+i.
  - Byte i is sampled from mem_data_out at the end of cycle T+i+RD_LATENCY, via rdata <= {rdata << 8, byte}.
  - rsp_valid is high in cycle T+N+RD_LATENCY+1.
  - Total latency is N+RD_LATENCY+1 cycles after accept, e.g. 7 for N=4, RD_LATENCY=2.
- rsp_rdata holds its value until the next load is accepted.
- FSM states and transitions:
  - IDLE: to ISSUE on legal accept; to RESP on illegal accept.
  - ISSUE: N cycles, issues addresses and writes. Loads go to DRAIN; stores go to RESP.
  - DRAIN: RD_LATENCY cycles while outstanding reads return. Then RESP.
  - RESP: one cycle with rsp_valid. Then IDLE; req_ready returns in the following cycle.
- A byte counter of width log2(DATA_BYTES)+1 is used for both ISSUE and DRAIN.
- req_valid during busy is ignored. It must be held by the master until it is accepted.

Decomposition:
- Package mem_seq_pkg holds:
  - size encodings SIZE_B / SIZE_W / SIZE_L / SIZE_Q
  - state enum IDLE / ISSUE / DRAIN / RESP
  - helper function size_to_bytes
- Sub-module rd_track: a RD_LATENCY-deep valid shift register. It marks which cycles carry returning read bytes and drives the capture enable.

Test Plan:
- Load, size 2, addr 0x010, RAM[0x10..0x13] = 12 34 56 78 -> rsp_rdata = 0x12345678; rsp_valid exactly 7 cycles after accept; req_ready low throughout.
- Store, size 1, addr 0x1FF, wdata 0xABCD -> writes RAM[0x1FF] = AB then RAM[0x000] = CD (wrap); exactly 2 mem_write pulses; rsp_valid at T+3.
- Byte load at 0x005 = 0x9C, RD_LATENCY = 3 build -> rsp_rdata = 0x0000009C at T+5.
- req_size = 3 with DATA_BYTES = 4 -> rsp_valid & rsp_error at T+1; no mem_write; rsp_rdata = 0.
- Reset asserted in cycle T+2 of a 4-byte store -> only 1 byte written; busy 0, req_ready 1, no rsp_valid afterwards.
- Back-to-back: req_valid held, store then load to the same address -> the load returns the newly stored value; second accept occurs the cycle after RESP.
